// File: rtl/stream_max_tracker_pkg.sv
// Shared types and constants for the stream max/min tracker.
package stream_max_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value a CNT_W-bit count/index can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned CNT_MAX   = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/stream_max_tracker_if.sv
// Sample-in / result-out handshake bundle for stream_max_tracker.
interface stream_max_tracker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] min_idx;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, max_val, min_val, max_idx, min_idx, count, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, max_val, min_val, max_idx, min_idx, count, ovf
  );
endinterface

// File: rtl/stream_max_tracker_mag_cmp.sv
// Combinational magnitude comparator, unsigned or two's-complement.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             lt
);
  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_k = a;
    b_k = b;
    if (is_signed) begin
      a_k[WIDTH-1] = ~a[WIDTH-1];
      b_k[WIDTH-1] = ~b[WIDTH-1];
    end
    gt = (a_k > b_k);
    lt = (a_k < b_k);
  end
endmodule

// File: rtl/stream_max_tracker.sv
// Per-frame running max/min/index/count tracker with registered result handshake.
module stream_max_tracker
  import stream_max_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 signed_mode,
  stream_max_tracker_if.slave  bus
);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_max(CNT_W));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             accept, gt_max, lt_min;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a(bus.in_data), .b(max_q), .is_signed(mode_q), .gt(gt_max), .lt()
  );
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a(bus.in_data), .b(min_q), .is_signed(mode_q), .gt(), .lt(lt_min)
  );

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.max_val   = max_q;
  assign bus.min_val   = min_q;
  assign bus.max_idx   = max_idx_q;
  assign bus.min_idx   = min_idx_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

  assign accept = bus.in_valid & (state_q != DONE) & ~clear;

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mode_d    = mode_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          max_d     = bus.in_data;
          min_d     = bus.in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = CNT_W'(1);
          ovf_d     = 1'b0;
          mode_d    = signed_mode & (SIGNED_EN != 0);
          state_d   = bus.in_last ? DONE : ACCUM;
        end
        // Index of this sample is the pre-edge count, which is already saturated.
        ACCUM: if (accept) begin
          if (gt_max) begin
            max_d     = bus.in_data;
            max_idx_d = count_q;
          end
          if (lt_min) begin
            min_d     = bus.in_data;
            min_idx_d = count_q;
          end
          if (count_q == SAT) ovf_d = 1'b1;
          else                count_d = count_q + 1'b1;
          if (bus.in_last) state_d = DONE;
        end
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mode_q    <= mode_d;
    end
  end
endmodule
